mem_lsu: RTL
============

Name: mem_lsu

Overview:
- Memory-stage load/store unit; sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Turns the EX/MEM access request into one data-bus transaction using a valid/ready request and rvalid response.
- Asserts a stall request to the pipeline controller while the transaction is outstanding.
- Presents the raw 64-bit bus word and byte-enable mask to MEM/WB; writeback does extraction and sign/zero extension using byte enable and ext_un.

Parameters:
XLEN, 64, data and address width; only 64 is supported.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ex_addr  in  XLEN  effective address (EX/MEM ALU result)
ex_store_data  in  XLEN  store data, right-aligned
ex_mem_read  in  1  load request
ex_mem_write  in  1  store request; never both high with ex_mem_read
ex_mem_size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword
wb_stall  in  2  stall code the controller drives to MEM/WB (STALL_NEXT/STALL_KEEP/STALL_ZERO)
me_mem_data  out  XLEN  captured read word (load) or zero (store / no access)
me_mem_byte_enable  out  8  lane mask of the current access
me_misalign  out  1  current access is misaligned
mem_stall_req  out  1  stall request to the controller
dbus_valid  out  1  request valid
dbus_ready  in  1  request accepted
dbus_addr  out  XLEN  ex_addr with bits [2:0] cleared
dbus_we  out  1  write request
dbus_wstrb  out  8  write lane mask
dbus_wdata  out  XLEN  ex_store_data shifted left by ex_addr[2:0]*8
dbus_rvalid  in  1  response valid (loads and stores)
dbus_rdata  in  XLEN  response data

Behaviour:
- Byte enable is combinational from the inputs:
  - byte: 8'h01 << addr[2:0]
  - half: 8'h03 << addr[2:0]
  - word: 8'h0F << addr[2:0]
  - dword: 8'hFF
  - Forced to 0 when there is no access or the access is misaligned.
- Misaligned means: half with addr[0]=1; word with addr[1:0]≠0; dword with addr[2:0]≠0.
  - me_misalign=1, no bus transaction, no stall.
- FSM has four states: IDLE, REQ, RESP, DONE.
- IDLE
  - If an access is present and aligned: go to REQ; mem_stall_req=1 combinationally this cycle.
  - Otherwise stay in IDLE.
- REQ
  - dbus_valid=1. dbus_addr, we, wstrb and wdata are held stable from the registered request.
  - dbus_ready=1 with dbus_rvalid=1 in the same cycle: capture the response, go to DONE.
  - dbus_ready=1 alone: go to RESP.
  - Otherwise stay in REQ; valid is never dropped before ready.
  - mem_stall_req=1.
- RESP
  - dbus_valid=0, mem_stall_req=1.
  - On dbus_rvalid: capture dbus_rdata (loads only; stores capture 0), go to DONE.
- DONE
  - mem_stall_req=0. me_mem_data holds the captured value.
  - wb_stall==STALL_NEXT: go to IDLE; the next instruction's access is evaluated the following cycle.
  - STALL_KEEP: stay in DONE and hold everything.
  - STALL_ZERO: go to IDLE.
- Minimum load latency, with ready on the first valid and rvalid the next cycle:
  - detect at cycle 0, valid at cycle 1, rvalid at cycle 2, DONE/data at cycle 3.
  - The stall is therefore released at cycle 3.
- dbus_rvalid outside REQ/RESP is ignored.
- A request is issued at most once per instruction.
- me_mem_data is 0 in IDLE.
- Reset (including mid-transaction): state IDLE; dbus_valid, dbus_we, dbus_wstrb, dbus_wdata, dbus_addr, me_mem_data and mem_stall_req all 0. The bus slave shares rst and abandons any outstanding transaction.

Decomposition:
- Shared defines.v holds REG_BUS, STALL_NEXT/STALL_KEEP/STALL_ZERO, the MEM_SIZE_B/H/W/D encodings, and the FSM state encodings.
- One combinational sub-module, lsu_align, computes byte enable, misalign, write-data shift and aligned address.

Test Plan:
- ld (size 11) at 0x8000_0010, ready on the first valid, rvalid next cycle with rdata 0x1122334455667788:
  - stall_req high at cycles 0-2, low at cycle 3.
  - me_mem_data=0x1122334455667788, byte_enable=0xFF.
- sb at 0x8000_0003, data 0xAB:
  - dbus_addr=0x8000_0000, wstrb=0x08, wdata=0x00000000AB000000, we=1.
  - me_mem_data=0 after rvalid.
- lw at 0x8000_0002:
  - me_misalign=1, byte_enable=0, dbus_valid never asserted, stall_req=0.
- lh at 0x8000_0006 with ready held low 3 cycles:
  - valid and address stable for 4 cycles, stall held throughout.
  - byte_enable=0xC0.
- Load reaches DONE while wb_stall=STALL_KEEP for 2 cycles, then STALL_NEXT:
  - data held, no second dbus_valid.
  - IDLE follows.
- rst asserted in RESP:
  - next cycle all outputs 0 and state IDLE.
  - A late rvalid is ignored.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared constants for the memory-stage load/store unit.
// Holds the bus width, the MEM/WB stall codes, the access size codes and the FSM states.
package mem_lsu_pkg;

    localparam int REG_BUS = 64;

    localparam logic [1:0] STALL_NEXT = 2'b00;
    localparam logic [1:0] STALL_KEEP = 2'b01;
    localparam logic [1:0] STALL_ZERO = 2'b10;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;
    localparam logic [1:0] MEM_SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational access decode: lane mask, misalignment, store-data lane shift, dword-aligned address.
// Zero latency; the mask is zero whenever there is no access or the access is misaligned.
module lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int XLEN = REG_BUS
) (
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic [1:0]      size,
    input  logic            access,
    output logic [7:0]      byte_enable,
    output logic            misalign,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] aligned_addr
);

    logic [7:0] be_raw;
    logic       misalign_raw;

    always_comb begin
        be_raw       = 8'h00;
        misalign_raw = 1'b0;
        case (size)
            MEM_SIZE_B: be_raw = 8'h01 << addr[2:0];
            MEM_SIZE_H: begin
                be_raw       = 8'h03 << addr[2:0];
                misalign_raw = addr[0];
            end
            MEM_SIZE_W: begin
                be_raw       = 8'h0F << addr[2:0];
                misalign_raw = (addr[1:0] != 2'b00);
            end
            default: begin
                be_raw       = 8'hFF;
                misalign_raw = (addr[2:0] != 3'b000);
            end
        endcase
    end

    assign misalign     = access & misalign_raw;
    assign byte_enable  = (access && !misalign_raw) ? be_raw : 8'h00;
    assign wdata        = store_data << {addr[2:0], 3'b000};
    assign aligned_addr = {addr[XLEN-1:3], 3'b000};

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one valid/ready bus request per aligned access, stall while outstanding.
// Data returns to MEM/WB as the raw 64-bit word; valid is held until ready, rvalid is ignored outside REQ/RESP.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int XLEN = REG_BUS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [1:0]      ex_mem_size,
    input  logic [1:0]      wb_stall,
    output logic [XLEN-1:0] me_mem_data,
    output logic [7:0]      me_mem_byte_enable,
    output logic            me_misalign,
    output logic            mem_stall_req,
    output logic            dbus_valid,
    input  logic            dbus_ready,
    output logic [XLEN-1:0] dbus_addr,
    output logic            dbus_we,
    output logic [7:0]      dbus_wstrb,
    output logic [XLEN-1:0] dbus_wdata,
    input  logic            dbus_rvalid,
    input  logic [XLEN-1:0] dbus_rdata
);

    lsu_state_t      state;
    logic            access;
    logic            go;
    logic            is_load;
    logic [XLEN-1:0] shifted_wdata;
    logic [XLEN-1:0] aligned_addr;

    assign access = ex_mem_read | ex_mem_write;

    lsu_align #(.XLEN(XLEN)) u_align (
        .addr         (ex_addr),
        .store_data   (ex_store_data),
        .size         (ex_mem_size),
        .access       (access),
        .byte_enable  (me_mem_byte_enable),
        .misalign     (me_misalign),
        .wdata        (shifted_wdata),
        .aligned_addr (aligned_addr)
    );

    // Misaligned accesses never reach the bus and never stall.
    assign go = access && !me_misalign;

    // The detect cycle stalls combinationally so the pipeline holds EX/MEM before the request registers.
    assign mem_stall_req = !rst && ((state == ST_IDLE && go) || state == ST_REQ || state == ST_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            dbus_valid  <= 1'b0;
            dbus_addr   <= '0;
            dbus_we     <= 1'b0;
            dbus_wstrb  <= 8'h00;
            dbus_wdata  <= '0;
            is_load     <= 1'b0;
            me_mem_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state      <= ST_REQ;
                        dbus_valid <= 1'b1;
                        dbus_addr  <= aligned_addr;
                        dbus_we    <= ex_mem_write;
                        dbus_wstrb <= ex_mem_write ? me_mem_byte_enable : 8'h00;
                        dbus_wdata <= shifted_wdata;
                        is_load    <= ex_mem_read;
                    end
                end
                ST_REQ: begin
                    if (dbus_ready) begin
                        dbus_valid <= 1'b0;
                        if (dbus_rvalid) begin
                            me_mem_data <= is_load ? dbus_rdata : '0;
                            state       <= ST_DONE;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (dbus_rvalid) begin
                        me_mem_data <= is_load ? dbus_rdata : '0;
                        state       <= ST_DONE;
                    end
                end
                default: begin
                    // Leaving DONE clears the word so IDLE always presents zero.
                    if (wb_stall != STALL_KEEP) begin
                        state       <= ST_IDLE;
                        me_mem_data <= '0;
                    end
                end
            endcase
        end
    end

endmodule
